// File: rtl/chu_ddfs_poly_core_if.sv
// chu_ddfs_poly_core_if
//   MMIO slot bus between a bus master and the polyphonic DDFS core.
//   cs       : slot select
//   read     : read strobe (reads are side-effect free)
//   write    : write strobe
//   addr     : register address
//   wr_data  : write data
//   rd_data  : read data, combinational from addr
interface chu_ddfs_poly_core_if;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    modport master (
        output cs, read, write, addr, wr_data,
        input  rd_data
    );

    modport slave (
        input  cs, read, write, addr, wr_data,
        output rd_data
    );
endinterface

// File: rtl/chu_ddfs_poly_core.sv
// chu_ddfs_poly_core
//   Polyphonic DDFS: NV sine voices share one time-multiplexed
//   phase -> sine ROM -> envelope -> accumulate pipeline and are mixed into
//   one signed 16-bit PCM sample every DIV clocks.
//
//   Ports
//     clk            system clock
//     reset          asynchronous, active-high reset
//     slot_if        MMIO slot bus (slave side)
//     pcm_out_o      mixed signed sample, registered
//     pdm_out_o      1-bit delta-sigma bitstream (0 unless DDFS_PDM_EN)
//     sample_tick_o  one-cycle pulse in the first cycle a new pcm_out_o is visible
//
//   Build option
//     DDFS_PDM_EN    builds the first-order delta-sigma modulator on pcm_out_o
//
//   Registers (addr[2:0])
//     0 voice_sel  1 fccw[voice_sel]  2 env[voice_sel]  3 en_mask
//     4 ctrl (bit0 = mix mode)  5 phase-clear strobe mask (write only)
module chu_ddfs_poly_core #(
    parameter int NV  = 4,
    parameter int PW  = 30,
    parameter int LW  = 10,
    parameter int DIV = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    chu_ddfs_poly_core_if.slave       slot_if,
    output logic [15:0]               pcm_out_o,
    output logic                      pdm_out_o,
    output logic                      sample_tick_o
);

    localparam int NVB   = $clog2(NV);
    localparam int VSW   = (NV > 1) ? $clog2(NV) : 1;
    localparam int FCW   = $clog2(DIV);
    localparam int AW    = 18 + NVB;
    localparam int ROM_N = 1 << LW;

    // Quarter-wave folded Taylor series, evaluated at elaboration time only.
    // int'() of a real rounds half away from zero, matching round().
    function automatic logic signed [15:0] sine_q15(input int k);
        int  h;
        int  q;
        int  r;
        real x;
        real term;
        real sum;
        bit  neg;
        neg  = (k >= ROM_N / 2);
        h    = neg ? k - ROM_N / 2 : k;
        q    = (h > ROM_N / 4) ? ROM_N / 2 - h : h;
        x    = 6.283185307179586 * real'(q) / real'(ROM_N);
        term = x;
        sum  = x;
        for (int n = 1; n < 12; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        r = int'(32767.0 * sum);
        return neg ? 16'(-r) : 16'(r);
    endfunction

    function automatic logic [15:0] sat16(input logic signed [AW-1:0] x);
        logic [15:0] res;
        if ((x[AW-1:15] == '0) || (x[AW-1:15] == '1))
            res = x[15:0];
        else
            res = x[AW-1] ? 16'h8000 : 16'h7FFF;
        return res;
    endfunction

    logic signed [15:0] sine_rom [ROM_N];
    for (genvar k = 0; k < ROM_N; k++) begin : g_rom
        assign sine_rom[k] = sine_q15(k);
    end

    // ---------------- register file ----------------
    logic [3:0]     voice_sel_q;
    logic [PW-1:0]  fccw_q [NV];
    logic [15:0]    env_q  [NV];
    logic [NV-1:0]  en_mask_q;
    logic           ctrl_q;

    logic           wr_en;
    logic [2:0]     wa;
    logic           sel_ok;
    logic [VSW-1:0] sel_idx;
    logic [NV-1:0]  clr_mask;

    assign wr_en    = slot_if.cs & slot_if.write;
    assign wa       = slot_if.addr[2:0];
    assign sel_ok   = ({1'b0, voice_sel_q} < 5'(NV));
    assign sel_idx  = voice_sel_q[VSW-1:0];
    assign clr_mask = (wr_en && (wa == 3'd5)) ? slot_if.wr_data[NV-1:0] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            voice_sel_q <= '0;
            en_mask_q   <= '0;
            ctrl_q      <= 1'b0;
            for (int v = 0; v < NV; v++) begin
                fccw_q[v] <= '0;
                env_q[v]  <= 16'h4000;
            end
        end else if (wr_en) begin
            case (wa)
                3'd0: voice_sel_q <= slot_if.wr_data[3:0];
                3'd1: if (sel_ok) fccw_q[sel_idx] <= slot_if.wr_data[PW-1:0];
                3'd2: if (sel_ok) env_q[sel_idx] <= slot_if.wr_data[15:0];
                3'd3: en_mask_q <= slot_if.wr_data[NV-1:0];
                3'd4: ctrl_q <= slot_if.wr_data[0];
                default: ;
            endcase
        end
    end

    always_comb begin
        slot_if.rd_data = '0;
        case (wa)
            3'd0: slot_if.rd_data = {16'h0, pcm_out_o};
            3'd1: if (sel_ok) slot_if.rd_data = 32'(fccw_q[sel_idx]);
            3'd2: if (sel_ok) slot_if.rd_data = {16'h0, env_q[sel_idx]};
            3'd3: slot_if.rd_data = 32'(en_mask_q);
            3'd4: slot_if.rd_data = {31'd0, ctrl_q};
            default: ;
        endcase
    end

    // ---------------- frame counter and voice issue ----------------
    logic [FCW-1:0] fc_q;
    logic           issue;
    logic [VSW-1:0] vidx;
    logic [PW-1:0]  phase_q [NV];
    logic [LW-1:0]  rom_addr;

    assign issue    = (fc_q < FCW'(NV));
    assign vidx     = fc_q[VSW-1:0];
    assign rom_addr = phase_q[vidx][PW-1 -: LW];

    // A clear strobe wins over the S0 update of the same voice; the ROM
    // address above was already taken from the pre-clear phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int v = 0; v < NV; v++) phase_q[v] <= '0;
        end else begin
            for (int v = 0; v < NV; v++) begin
                if (clr_mask[v])
                    phase_q[v] <= '0;
                else if (issue && (vidx == VSW'(v)) && en_mask_q[v])
                    phase_q[v] <= phase_q[v] + fccw_q[v];
            end
        end
    end

    // ---------------- datapath S1..S3 and output ----------------
    logic signed [15:0]   sin_s1_q;
    logic [15:0]          env_s1_q;
    logic                 en_s1_q;
    logic                 vld_s1_q;
    logic signed [32:0]   mul;
    logic signed [17:0]   prod_d;
    logic signed [17:0]   prod_s2_q;
    logic                 en_s2_q;
    logic                 vld_s2_q;
    logic signed [AW-1:0] acc_q;
    logic signed [AW-1:0] acc_d;
    logic [15:0]          pcm_q;
    logic                 tick_q;
    logic                 out_slot;

    assign mul      = sin_s1_q * $signed({1'b0, env_s1_q});
    assign prod_d   = 18'(mul >>> 14);
    assign out_slot = (fc_q == FCW'(NV + 3));

    always_comb begin
        acc_d = acc_q;
        if (fc_q == '0)
            acc_d = '0;
        else if (vld_s2_q && en_s2_q)
            acc_d = acc_q + AW'(prod_s2_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fc_q      <= '0;
            sin_s1_q  <= '0;
            env_s1_q  <= '0;
            en_s1_q   <= 1'b0;
            vld_s1_q  <= 1'b0;
            prod_s2_q <= '0;
            en_s2_q   <= 1'b0;
            vld_s2_q  <= 1'b0;
            acc_q     <= '0;
            pcm_q     <= '0;
            tick_q    <= 1'b0;
        end else begin
            fc_q      <= (fc_q == FCW'(DIV - 1)) ? '0 : fc_q + 1'b1;
            sin_s1_q  <= sine_rom[rom_addr];
            env_s1_q  <= env_q[vidx];
            en_s1_q   <= en_mask_q[vidx];
            vld_s1_q  <= issue;
            prod_s2_q <= prod_d;
            en_s2_q   <= en_s1_q;
            vld_s2_q  <= vld_s1_q;
            acc_q     <= acc_d;
            tick_q    <= out_slot;
            if (out_slot)
                pcm_q <= sat16(ctrl_q ? (acc_q >>> NVB) : acc_q);
        end
    end

    assign pcm_out_o     = pcm_q;
    assign sample_tick_o = tick_q;

`ifdef DDFS_PDM_EN
    // Offset-binary input; the carry out of the 16-bit sum is the bitstream.
    logic [15:0] pdm_acc_q;
    logic        pdm_q;
    logic [16:0] pdm_sum;

    assign pdm_sum = {1'b0, pdm_acc_q} + {1'b0, pcm_q ^ 16'h8000};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pdm_acc_q <= '0;
            pdm_q     <= 1'b0;
        end else begin
            pdm_acc_q <= pdm_sum[15:0];
            pdm_q     <= pdm_sum[16];
        end
    end

    assign pdm_out_o = pdm_q;
`else
    assign pdm_out_o = 1'b0;
`endif

    logic unused_bus;
    assign unused_bus = ^{slot_if.read, slot_if.addr[4:3], slot_if.wr_data};

endmodule

// File: tb/tb_chu_ddfs_poly_core.sv
module tb_chu_ddfs_poly_core;
    localparam int NV  = 4;
    localparam int DIV = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pcm_out;
    logic        pdm_out;
    logic        sample_tick;

    int tests_run    = 0;
    int tests_failed = 0;

    chu_ddfs_poly_core_if bus();

    chu_ddfs_poly_core #(.NV(NV), .PW(30), .LW(10), .DIV(DIV)) dut (
        .clk           (clk),
        .reset         (reset),
        .slot_if       (bus),
        .pcm_out_o     (pcm_out),
        .pdm_out_o     (pdm_out),
        .sample_tick_o (sample_tick)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        bus.cs      = 1'b0;
        bus.read    = 1'b0;
        bus.write   = 1'b0;
        bus.addr    = '0;
        bus.wr_data = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic reg_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.cs      = 1'b1;
        bus.write   = 1'b1;
        bus.addr    = a;
        bus.wr_data = d;
        @(negedge clk);
        bus.cs      = 1'b0;
        bus.write   = 1'b0;
    endtask

    task automatic reg_read(input logic [4:0] a, output logic [31:0] d);
        bus.addr = a;
        bus.read = 1'b1;
        #1;
        d = bus.rd_data;
        bus.read = 1'b0;
    endtask

    task automatic wait_tick(output logic signed [15:0] s);
        bit seen;
        seen = 1'b0;
        s    = '0;
        for (int i = 0; i < 2 * DIV && !seen; i++) begin
            @(negedge clk);
            if (sample_tick) begin
                seen = 1'b1;
                s    = pcm_out;
            end
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL tick_timeout: no sample_tick within %0d cycles", 2 * DIV);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic signed [15:0] s;
        int cnt;
        bus.cs = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
        bus.addr = '0; bus.wr_data = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (pcm_out !== 16'h0 || sample_tick !== 1'b0 || pdm_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got pcm=%h tick=%b pdm=%b, expected 0/0/0", pcm_out, sample_tick, pdm_out);
        end
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 2 * DIV; i++) begin
            @(negedge clk);
            cnt++;
            if (sample_tick) break;
        end
        tests_run++;
        if (cnt !== NV + 4) begin
            tests_failed++;
            $display("FAIL first_tick_latency: got %0d cycles, expected %0d", cnt, NV + 4);
        end
        for (int f = 0; f < 3; f++) begin
            cnt = 0;
            for (int i = 0; i < 2 * DIV; i++) begin
                @(negedge clk);
                cnt++;
                if (sample_tick) break;
            end
            s = pcm_out;
            tests_run++;
            if (cnt !== DIV || s !== 16'sd0) begin
                tests_failed++;
                $display("FAIL idle_frame%0d: got period=%0d pcm=%0d, expected %0d/0", f, cnt, s, DIV);
            end
        end
        reg_read(5'd2, d);
        tests_run++;
        if (d !== 32'h4000) begin
            tests_failed++;
            $display("FAIL reset_env: got %h expected 00004000", d);
        end
        reg_read(5'd1, d);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_fccw: got %h expected 0", d);
        end
        reg_read(5'd3, d);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_en_mask: got %h expected 0", d);
        end
    endtask

    task automatic test_voice0();
        logic signed [15:0] s;
        int exp, tol;
        bit chk;
        do_reset();
        reg_write(5'd1, 32'h0100_0000);
        wait_tick(s);
        reg_write(5'd3, 32'h1);
        for (int k = 0; k <= 112; k++) begin
            wait_tick(s);
            chk = 1'b1; tol = 0; exp = 0;
            case (k)
                0:   exp = 0;
                4:   exp = 12539;
                8:   exp = 23170;
                16:  begin exp = 32767;  tol = 1; end
                32:  exp = 0;
                48:  begin exp = -32767; tol = 1; end
                64:  exp = 0;
                80:  exp = 16383;
                112: exp = -16384;
                default: chk = 1'b0;
            endcase
            if (chk) begin
                tests_run++;
                if ((int'(s) - exp) > tol || (exp - int'(s)) > tol) begin
                    tests_failed++;
                    $display("FAIL voice0_sample%0d: got %0d expected %0d (+-%0d)", k, s, exp, tol);
                end
            end
            if (k == 64) reg_write(5'd2, 32'h2000);
        end
    endtask

    task automatic test_all_voices();
        logic signed [15:0] s;
        int exp, tol;
        bit chk;
        do_reset();
        for (int v = 0; v < NV; v++) begin
            reg_write(5'd0, 32'(v));
            reg_write(5'd1, 32'h0100_0000);
        end
        wait_tick(s);
        reg_write(5'd3, 32'hF);
        for (int k = 0; k <= 112; k++) begin
            wait_tick(s);
            chk = 1'b1; tol = 0; exp = 0;
            case (k)
                16:  exp = 32767;
                48:  exp = -32768;
                56:  exp = -23170;
                64:  exp = 0;
                80:  begin exp = 32767; tol = 1; end
                88:  exp = 32767;
                112: exp = -32768;
                default: chk = 1'b0;
            endcase
            if (chk) begin
                tests_run++;
                if ((int'(s) - exp) > tol || (exp - int'(s)) > tol) begin
                    tests_failed++;
                    $display("FAIL mix4_sample%0d: got %0d expected %0d (+-%0d)", k, s, exp, tol);
                end
            end
            if (k == 48) reg_write(5'd4, 32'h1);
            if (k == 80) begin
                for (int v = 0; v < NV; v++) begin
                    reg_write(5'd0, 32'(v));
                    reg_write(5'd2, 32'h8000);
                end
            end
        end
    endtask

    task automatic test_enable_hold();
        logic signed [15:0] s;
        int exp;
        bit chk;
        do_reset();
        reg_write(5'd0, 32'h1);
        reg_write(5'd1, 32'h0100_0000);
        wait_tick(s);
        reg_write(5'd3, 32'h2);
        for (int t = 0; t <= 11; t++) begin
            wait_tick(s);
            chk = 1'b1; exp = 0;
            case (t)
                4:  exp = 12539;
                5:  exp = 0;
                6:  exp = 0;
                7:  exp = 0;
                8:  exp = 15446;
                11: exp = 23170;
                default: chk = 1'b0;
            endcase
            if (chk) begin
                tests_run++;
                if (int'(s) !== exp) begin
                    tests_failed++;
                    $display("FAIL hold_tick%0d: got %0d expected %0d", t, s, exp);
                end
            end
            if (t == 4) reg_write(5'd3, 32'h0);
            if (t == 7) reg_write(5'd3, 32'h2);
        end
    endtask

    task automatic test_phase_clear();
        logic signed [15:0] s;
        do_reset();
        reg_write(5'd0, 32'h2);
        reg_write(5'd1, 32'h0100_0000);
        wait_tick(s);
        reg_write(5'd3, 32'h4);
        for (int k = 0; k <= 8; k++) wait_tick(s);
        // tick observed at fc=8; 58 cycles later is fc=2 of the next frame
        repeat (57) @(negedge clk);
        reg_write(5'd5, 32'h4);
        wait_tick(s);
        tests_run++;
        if (s !== 16'sd25329) begin
            tests_failed++;
            $display("FAIL clr_preclear_addr: got %0d expected 25329", s);
        end
        wait_tick(s);
        tests_run++;
        if (s !== 16'sd0) begin
            tests_failed++;
            $display("FAIL clr_restart: got %0d expected 0", s);
        end
        for (int k = 0; k < 4; k++) wait_tick(s);
        tests_run++;
        if (s !== 16'sd12539) begin
            tests_failed++;
            $display("FAIL clr_resume: got %0d expected 12539", s);
        end
    endtask

    task automatic test_regs();
        logic [31:0] d;
        do_reset();
        reg_write(5'd0, 32'h2);
        reg_write(5'd1, 32'h123);
        reg_read(5'd1, d);
        tests_run++;
        if (d !== 32'h123) begin
            tests_failed++;
            $display("FAIL rd_fccw2: got %h expected 00000123", d);
        end
        reg_read(5'd0, d);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++;
            $display("FAIL rd_pcm: got %h expected 0", d);
        end
        reg_write(5'd0, 32'h7);
        reg_write(5'd1, 32'hABC);
        reg_write(5'd2, 32'h1111);
        reg_read(5'd1, d);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++;
            $display("FAIL rd_fccw_badsel: got %h expected 0", d);
        end
        reg_read(5'd2, d);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++;
            $display("FAIL rd_env_badsel: got %h expected 0", d);
        end
        reg_write(5'd0, 32'h2);
        reg_read(5'd1, d);
        tests_run++;
        if (d !== 32'h123) begin
            tests_failed++;
            $display("FAIL fccw2_kept: got %h expected 00000123", d);
        end
        reg_read(5'd2, d);
        tests_run++;
        if (d !== 32'h4000) begin
            tests_failed++;
            $display("FAIL env2_kept: got %h expected 00004000", d);
        end
        reg_write(5'd3, 32'hFFFF_FFFF);
        reg_read(5'd3, d);
        tests_run++;
        if (d !== 32'hF) begin
            tests_failed++;
            $display("FAIL rd_en_mask: got %h expected 0000000f", d);
        end
        reg_write(5'd4, 32'h0000_FFFF);
        reg_read(5'd4, d);
        tests_run++;
        if (d !== 32'h1) begin
            tests_failed++;
            $display("FAIL rd_ctrl: got %h expected 00000001", d);
        end
        reg_read(5'd6, d);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++;
            $display("FAIL rd_unmapped: got %h expected 0", d);
        end
    endtask

    task automatic test_pdm();
        logic signed [15:0] s;
        int ones;
        do_reset();
        reg_write(5'd1, 32'h0100_0000);
        wait_tick(s);
        reg_write(5'd3, 32'h1);
        for (int k = 0; k <= 15; k++) wait_tick(s);
        reg_write(5'd1, 32'h0);
        reg_write(5'd2, 32'h2000);
        wait_tick(s);
        tests_run++;
        if (s !== 16'sd16383) begin
            tests_failed++;
            $display("FAIL pdm_held_pcm: got %0d expected 16383", s);
        end
        ones = 0;
        for (int i = 0; i < 4096; i++) begin
            @(negedge clk);
            if (pdm_out === 1'b1) ones++;
        end
        tests_run++;
`ifdef DDFS_PDM_EN
        if (ones < 3060 || ones > 3085) begin
            tests_failed++;
            $display("FAIL pdm_density: got %0d ones in 4096 expected about 3072", ones);
        end
`else
        if (ones !== 0) begin
            tests_failed++;
            $display("FAIL pdm_tied_low: got %0d ones expected 0", ones);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_regs();
        test_voice0();
        test_all_voices();
        test_enable_hold();
        test_phase_clear();
        test_pdm();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
